spi_regbank: RTL
================

Name: spi_regbank

Overview:
- System-clock register bank downstream of the 16-bit SPI slave.
- Synchronizes the slave's transaction qualifiers (`spien`, `wrt`, `rdt`) into `clk`.
- Commits completed write transactions into 12 control registers and supplies read data for the slave's MISO shift register.
- Exposes the control registers to the motor-control datapath and issues per-access strobes.

Parameters:
- NCTRL, 12, number of writable control registers (addresses 0..NCTRL-1). Addresses NCTRL..15 are read-only status.
- SYNC_STAGES, 2, flop depth of every clock-domain-crossing synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spien  in  1  SPI select from slave (spiclk domain)
- wrt  in  1  write-transaction indicator from slave
- rdt  in  1  read-transaction indicator from slave
- addr  in  4  register address from slave
- wrtdata  in  8  write data from slave
- rddata  out  8  read data to slave parallel input
- statusin  in  (16-NCTRL)*8  status words; word k maps to address NCTRL+k
- faultin  in  8  fault event bits (used only with the optional feature)
- ctrlregs  out  NCTRL*8  flattened control registers; register n occupies bits [8n+7:8n]
- wrstb  out  1  one-clk pulse when a control register is updated
- wraddr  out  4  address of the last committed write; valid with wrstb, held otherwise
- rdstb  out  1  one-clk pulse at end of a read transaction
- rdaddr  out  4  address of the last completed read; valid with rdstb, held otherwise

Behaviour:
- Clock and reset are decided: one clock, `clk`; reset `reset` is synchronous and active-high.
- **Reset values:**
  - All `ctrlregs`, `rddata`, `wraddr`, `rdaddr` = 0.
  - `wrstb`, `rdstb` = 0.
  - FSM = IDLE.
  - Synchronizer flops = 0.
  - The "previous `spien_s`" flop resets to 1, so no start edge is detected until `spien_s` has been seen low.
- **Synchronizers:** `spien`, `wrt` and `rdt` each pass through SYNC_STAGES flops, giving `spien_s`, `wrt_s`, `rdt_s`. `addr` and `wrtdata` are not synchronized; they are sampled only in COMMIT, when `spiclk` is idle and the slave holds them stable.
- **FSM:**
  - IDLE: rising edge of `spien_s` -> ACTIVE; clear `wrseen` and `rdseen`.
  - ACTIVE:
    - `wrseen` |= `wrt_s`; `rdseen` |= `rdt_s`.
    - Falling edge of `spien_s` -> COMMIT.
  - COMMIT (exactly 1 clk):
    - If `wrseen` and `addr` < NCTRL: `ctrlregs[addr]` <= `wrtdata`; `wrstb`=1; `wraddr`=`addr`.
    - If `wrseen` and `addr` >= NCTRL: write discarded, no `wrstb`.
    - If `rdseen`: `rdstb`=1; `rdaddr`=`addr`.
    - Always -> IDLE.
- **Aborted transactions:** a transaction where `spien` deasserts before `wrt` ever asserts (fewer than 9 `spiclk` edges) commits nothing. A truncated write (`wrt` seen, fewer than 16 bits) commits `wrtdata` as shifted; the master is responsible for full frames.
- **Read data path:**
  - Every clk, `rddata` <= value at `addr` (control or status), through a 2-flop `addr` capture stage.
  - Latency from `addr` change to `rddata` = 3 clk.
  - Timing requirement: the `spiclk` half-period must be >= (SYNC_STAGES+4) `clk` periods, so `rddata` is stable before the slave loads on its 9th edge.
- **Reset during ACTIVE:** the FSM returns to IDLE and pending `wrseen`/`rdseen` are dropped. The in-flight transaction is ignored, because the previous-`spien_s` flop resets to 1.
- **Back-to-back transactions:** a new rising edge is detected only from IDLE. COMMIT is a single cycle, so a gap of >= SYNC_STAGES+2 clk between transactions is sufficient.
- **Strobes:** `wrstb` and `rdstb` are high for exactly one clk per transaction; both never assert together for one transaction, since the slave mode is exclusive.

Optional Feature:
- Macro: SPI_REGBANK_FAULTLATCH_EN.
- **Defined:**
  - Address 15 reads a sticky fault register: each bit is set by `faultin` bit high on any clk.
  - It is cleared in the COMMIT cycle of a read whose `addr`=15.
  - A bit asserted on `faultin` in that same cycle remains set (set wins).
  - Reset clears it.
- **Undefined:** address 15 reads `statusin` word 15-NCTRL directly, and `faultin` is ignored.

Decomposition:
- **Shared package:**
  - SPI_ADDR_W=4, SPI_DATA_W=8, SPI_NREGS=16.
  - FSM state enum {IDLE, ACTIVE, COMMIT}.
  - Address constant FAULT_ADDR=15.
- **Sub-module:** one natural sub-module, `spi_sync_bit` (SYNC_STAGES-deep single-bit synchronizer), instantiated 3 times.

Test Plan:
- Reset, then hold `spien`=0 -> all `ctrlregs`=0, `rddata`=0, no strobes.
- Write transaction, `addr`=3, `wrtdata`=0xA5 (`spien` high, `wrt` high for 8 `spiclk`, `spien` low) -> `ctrlregs[31:24]`=0xA5 and `wrstb` pulses one clk with `wraddr`=3, within SYNC_STAGES+2 clk of `spien` falling.
- Read transaction, `addr`=13 with `statusin` word1=0x5C -> `rddata`=0x5C within 3 clk of `addr` settling; `rdstb` pulses once with `rdaddr`=13; `ctrlregs` unchanged.
- Write to `addr`=14, data 0xFF -> no `wrstb`, all `ctrlregs` unchanged.
- Abort: `spien` high for 5 `spiclk` then low (`wrt` never high) -> no write, no strobes. Then assert `reset` mid-ACTIVE with `spien` held high and `wrt` high -> no commit after reset releases.
- With SPI_REGBANK_FAULTLATCH_EN: pulse `faultin`=0x04 -> read `addr` 15 returns 0x04. Read commit clears it to 0x00, except when `faultin`=0x01 coincides with COMMIT, in which case the result is 0x01.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// Shared constants and types for the SPI register bank slice.
// Used by spi_regbank and spi_sync_bit.
package spi_regbank_pkg;

  localparam int SPI_ADDR_W = 4;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_NREGS  = 16;

  localparam logic [SPI_ADDR_W-1:0] FAULT_ADDR = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync_bit.sv
// Single-bit synchronizer, STAGES flops deep, cleared by synchronous reset.
module spi_sync_bit
  import spi_regbank_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_regbank.sv
// System-clock register bank behind the 16-bit SPI slave: commits writes, serves read data, issues strobes.
// Optional sticky fault register at address 15 enabled by SPI_REGBANK_FAULTLATCH_EN.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int NCTRL       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     spien,
  input  logic                                     wrt,
  input  logic                                     rdt,
  input  logic [SPI_ADDR_W-1:0]                    addr,
  input  logic [SPI_DATA_W-1:0]                    wrtdata,
  output logic [SPI_DATA_W-1:0]                    rddata,
  input  logic [(SPI_NREGS-NCTRL)*SPI_DATA_W-1:0]  statusin,
  input  logic [SPI_DATA_W-1:0]                    faultin,
  output logic [NCTRL*SPI_DATA_W-1:0]              ctrlregs,
  output logic                                     wrstb,
  output logic [SPI_ADDR_W-1:0]                    wraddr,
  output logic                                     rdstb,
  output logic [SPI_ADDR_W-1:0]                    rdaddr
);

  localparam int NSTAT = SPI_NREGS - NCTRL;
  localparam logic [SPI_ADDR_W-1:0] NCTRL_A = SPI_ADDR_W'(NCTRL);

  logic spien_s;
  logic wrt_s;
  logic rdt_s;

  spi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_spien (
    .clk   (clk),
    .reset (reset),
    .din   (spien),
    .dout  (spien_s)
  );

  spi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wrt (
    .clk   (clk),
    .reset (reset),
    .din   (wrt),
    .dout  (wrt_s)
  );

  spi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rdt (
    .clk   (clk),
    .reset (reset),
    .din   (rdt),
    .dout  (rdt_s)
  );

  logic                   spien_prev_q, spien_prev_d;
  logic [SYNC_STAGES-1:0] warm_q, warm_d;
  state_e                 state_q, state_d;
  logic                   wrseen_q, wrseen_d;
  logic                   rdseen_q, rdseen_d;
  logic [SPI_DATA_W-1:0]  ctrl_q [NCTRL];
  logic [SPI_DATA_W-1:0]  ctrl_d [NCTRL];
  logic                   wrstb_q, wrstb_d;
  logic [SPI_ADDR_W-1:0]  wraddr_q, wraddr_d;
  logic                   rdstb_q, rdstb_d;
  logic [SPI_ADDR_W-1:0]  rdaddr_q, rdaddr_d;
  logic [SPI_ADDR_W-1:0]  addr_p1_q, addr_p1_d;
  logic [SPI_ADDR_W-1:0]  addr_p2_q, addr_p2_d;
  logic [SPI_DATA_W-1:0]  rddata_q, rddata_d;
  logic                   spien_rise;
  logic                   spien_fall;
  logic                   commit;

  // The synchronizers restart from 0 after reset; until they have refilled, hold the previous
  // value at 1 so an spien that stayed high through reset is not mistaken for a new start.
  always_comb begin
    warm_d       = {warm_q[SYNC_STAGES-2:0], 1'b1};
    spien_prev_d = warm_q[SYNC_STAGES-1] ? spien_s : 1'b1;
    spien_rise   = spien_s & ~spien_prev_q;
    spien_fall   = ~spien_s & spien_prev_q;
  end

  always_comb begin
    state_d  = state_q;
    wrseen_d = wrseen_q;
    rdseen_d = rdseen_q;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (spien_rise) begin
          state_d  = ACTIVE;
          wrseen_d = 1'b0;
          rdseen_d = 1'b0;
        end
      end
      ACTIVE: begin
        wrseen_d = wrseen_q | wrt_s;
        rdseen_d = rdseen_q | rdt_s;
        if (spien_fall) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // addr and wrtdata are sampled only here, while spiclk is idle and the slave holds them.
  always_comb begin
    ctrl_d   = ctrl_q;
    wrstb_d  = 1'b0;
    wraddr_d = wraddr_q;
    rdstb_d  = 1'b0;
    rdaddr_d = rdaddr_q;
    if (commit && wrseen_q && (addr < NCTRL_A)) begin
      for (int n = 0; n < NCTRL; n++) begin
        if (addr == SPI_ADDR_W'(n)) begin
          ctrl_d[n] = wrtdata;
        end
      end
      wrstb_d  = 1'b1;
      wraddr_d = addr;
    end
    if (commit && rdseen_q) begin
      rdstb_d  = 1'b1;
      rdaddr_d = addr;
    end
  end

`ifdef SPI_REGBANK_FAULTLATCH_EN
  logic [SPI_DATA_W-1:0] fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (commit && rdseen_q && (addr == FAULT_ADDR)) begin
      fault_d = '0;
    end
    fault_d = fault_d | faultin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  logic fault_unused;
  assign fault_unused = ^faultin;
`endif

  always_comb begin
    addr_p1_d = addr;
    addr_p2_d = addr_p1_q;
    rddata_d  = '0;
    for (int n = 0; n < NCTRL; n++) begin
      if (addr_p2_q == SPI_ADDR_W'(n)) begin
        rddata_d = ctrl_q[n];
      end
    end
    for (int k = 0; k < NSTAT; k++) begin
      if (addr_p2_q == SPI_ADDR_W'(NCTRL + k)) begin
        rddata_d = statusin[k*SPI_DATA_W +: SPI_DATA_W];
      end
    end
`ifdef SPI_REGBANK_FAULTLATCH_EN
    if (addr_p2_q == FAULT_ADDR) begin
      rddata_d = fault_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spien_prev_q <= 1'b1;
      warm_q       <= '0;
      state_q      <= IDLE;
      wrseen_q     <= 1'b0;
      rdseen_q     <= 1'b0;
      for (int n = 0; n < NCTRL; n++) begin
        ctrl_q[n] <= '0;
      end
      wrstb_q      <= 1'b0;
      wraddr_q     <= '0;
      rdstb_q      <= 1'b0;
      rdaddr_q     <= '0;
      addr_p1_q    <= '0;
      addr_p2_q    <= '0;
      rddata_q     <= '0;
    end else begin
      spien_prev_q <= spien_prev_d;
      warm_q       <= warm_d;
      state_q      <= state_d;
      wrseen_q     <= wrseen_d;
      rdseen_q     <= rdseen_d;
      ctrl_q       <= ctrl_d;
      wrstb_q      <= wrstb_d;
      wraddr_q     <= wraddr_d;
      rdstb_q      <= rdstb_d;
      rdaddr_q     <= rdaddr_d;
      addr_p1_q    <= addr_p1_d;
      addr_p2_q    <= addr_p2_d;
      rddata_q     <= rddata_d;
    end
  end

  always_comb begin
    ctrlregs = '0;
    for (int n = 0; n < NCTRL; n++) begin
      ctrlregs[n*SPI_DATA_W +: SPI_DATA_W] = ctrl_q[n];
    end
  end

  assign rddata = rddata_q;
  assign wrstb  = wrstb_q;
  assign wraddr = wraddr_q;
  assign rdstb  = rdstb_q;
  assign rdaddr = rdaddr_q;

endmodule
